// File: rtl/cone_lbist_ctrl.sv
// Logic-BIST sequencer for a single-output combinational cone: LFSR vectors
// are held for SETTLE cycles, the cone output is compacted into a 16-bit MISR.
module cone_lbist_ctrl #(
  parameter int unsigned      NIN    = 35,
  parameter logic [NIN-1:0]   TAPS   = 35'h5_0000_0000,
  parameter logic [NIN-1:0]   SEED   = 35'h1,
  parameter int unsigned      NPAT   = 1024,
  parameter int unsigned      SETTLE = 1,
  parameter logic [15:0]      GOLDEN = 16'h0000
) (
  input  logic           CK,
  input  logic           RST_N,
  input  logic           start,
  input  logic           abort,
  output logic [NIN-1:0] cone_in,
  input  logic           cone_out,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [15:0]    signature,
  output logic [15:0]    pat_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_SEED, S_APPLY, S_CAPTURE, S_CHECK, S_DONE
  } state_t;

  localparam logic [NIN-1:0] SEED_EFF    = (SEED == '0) ? NIN'(1) : SEED;
  localparam logic [3:0]     SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [15:0]    NPAT_LAST   = 16'(NPAT - 1);

  state_t         state;
  logic [NIN-1:0] lfsr;
  logic [15:0]    misr;
  logic [3:0]     settle_cnt;

  logic           misr_fb;
  logic [15:0]    misr_next;
  logic [NIN-1:0] lfsr_next;

  assign misr_fb   = misr[15] ^ cone_out;
  assign misr_next = {misr[14:0], 1'b0} ^ (misr_fb ? 16'h1021 : 16'h0000);
  assign lfsr_next = {lfsr[NIN-2:0], ^(lfsr & TAPS)};
  assign signature = misr;

  always_ff @(posedge CK) begin
    done <= 1'b0;
    if (!RST_N) begin
      state      <= S_IDLE;
      lfsr       <= SEED_EFF;
      misr       <= '0;
      pat_cnt    <= '0;
      settle_cnt <= '0;
      cone_in    <= '0;
      busy       <= 1'b0;
      pass       <= 1'b0;
    end else if (abort && state != S_IDLE) begin
      // misr and pat_cnt deliberately left intact for post-mortem inspection
      state      <= S_IDLE;
      settle_cnt <= '0;
      busy       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_SEED;
            busy  <= 1'b1;
          end
        end
        S_SEED: begin
          lfsr       <= SEED_EFF;
          misr       <= '0;
          pat_cnt    <= '0;
          pass       <= 1'b0;
          settle_cnt <= '0;
          cone_in    <= SEED_EFF;
          state      <= S_APPLY;
        end
        S_APPLY: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            state      <= S_CAPTURE;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        S_CAPTURE: begin
          misr <= misr_next;
          lfsr <= lfsr_next;
          if (pat_cnt != '1) pat_cnt <= pat_cnt + 16'd1;
          // cone_in is registered, so the next vector is loaded alongside the LFSR
          if (pat_cnt == NPAT_LAST) begin
            state <= S_CHECK;
          end else begin
            state   <= S_APPLY;
            cone_in <= lfsr_next;
          end
        end
        S_CHECK: begin
          pass  <= (misr == GOLDEN);
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cone_lbist_ctrl.sv
// Bench for cone_lbist_ctrl: several parameterisations run directed phases,
// random cones are checked against a software LFSR/MISR reference.
module tb_cone_lbist_ctrl;

  logic CK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CK = ~CK;

  int checks = 0;
  int failures = 0;

  // constant-one cone, two goldens
  logic        start_a = 1'b0, abort_a = 1'b0;
  logic [34:0] ci_a, ci_z;
  logic        busy_a, done_a, pass_a, busy_z, done_z, pass_z;
  logic [15:0] sig_a, pc_a, sig_z, pc_z;
  // LFSR sequence instance
  logic        start_b = 1'b0, abort_b = 1'b0;
  logic [34:0] ci_b;
  logic        busy_b, done_b, pass_b;
  logic [15:0] sig_b, pc_b;
  // abort instance, random cone
  logic        start_c = 1'b0, abort_c = 1'b0;
  logic [34:0] ci_c;
  logic        busy_c, done_c, pass_c, co_c;
  logic [15:0] sig_c, pc_c;
  // zero seed, long random run
  logic        start_d = 1'b0, abort_d = 1'b0;
  logic [34:0] ci_d;
  logic        busy_d, done_d, pass_d, co_d;
  logic [15:0] sig_d, pc_d;

  logic [34:0] cmask = '0;
  int          cp = 0, cq = 0;

  always_comb co_c = (^(ci_c & cmask)) ^ (ci_c[cp] & ci_c[cq]);
  always_comb co_d = (^(ci_d & cmask)) ^ (ci_d[cp] & ci_d[cq]);

  cone_lbist_ctrl #(.NPAT(4), .SETTLE(1), .GOLDEN(16'hF1EF)) u_one (
    .CK(CK), .RST_N(RST_N), .start(start_a), .abort(abort_a), .cone_in(ci_a),
    .cone_out(1'b1), .busy(busy_a), .done(done_a), .pass(pass_a),
    .signature(sig_a), .pat_cnt(pc_a));

  cone_lbist_ctrl #(.NPAT(4), .SETTLE(1), .GOLDEN(16'h0000)) u_one0 (
    .CK(CK), .RST_N(RST_N), .start(start_a), .abort(abort_a), .cone_in(ci_z),
    .cone_out(1'b1), .busy(busy_z), .done(done_z), .pass(pass_z),
    .signature(sig_z), .pat_cnt(pc_z));

  cone_lbist_ctrl #(.SEED(35'h1), .NPAT(3), .SETTLE(3)) u_seq (
    .CK(CK), .RST_N(RST_N), .start(start_b), .abort(abort_b), .cone_in(ci_b),
    .cone_out(1'b0), .busy(busy_b), .done(done_b), .pass(pass_b),
    .signature(sig_b), .pat_cnt(pc_b));

  cone_lbist_ctrl #(.NPAT(8), .SETTLE(1)) u_ab (
    .CK(CK), .RST_N(RST_N), .start(start_c), .abort(abort_c), .cone_in(ci_c),
    .cone_out(co_c), .busy(busy_c), .done(done_c), .pass(pass_c),
    .signature(sig_c), .pat_cnt(pc_c));

  cone_lbist_ctrl #(.SEED(35'h0), .NPAT(1024), .SETTLE(2)) u_rnd (
    .CK(CK), .RST_N(RST_N), .start(start_d), .abort(abort_d), .cone_in(ci_d),
    .cone_out(co_d), .busy(busy_d), .done(done_d), .pass(pass_d),
    .signature(sig_d), .pat_cnt(pc_d));

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: primitive trinomial x^35+x^33+1 shifted left, CCITT-polynomial MISR.
  function automatic logic [34:0] ref_lfsr(input logic [34:0] v);
    return {v[33:0], v[34] ^ v[32]};
  endfunction

  function automatic logic [15:0] ref_misr(input logic [15:0] s, input logic b);
    logic [15:0] r;
    r = s << 1;
    if (s[15] ^ b) r = r ^ 16'h1021;
    return r;
  endfunction

  function automatic logic ref_cone(input logic [34:0] v, input logic [34:0] m,
                                    input int p, input int q);
    return (^(v & m)) ^ (v[p] & v[q]);
  endfunction

  function automatic logic [15:0] ref_sig(input logic [34:0] seed, input int n,
                                          input logic [34:0] m, input int p, input int q);
    logic [34:0] v;
    logic [15:0] s;
    v = (seed == 35'h0) ? 35'h1 : seed;
    s = 16'h0;
    for (int i = 0; i < n; i++) begin
      s = ref_misr(s, ref_cone(v, m, p, q));
      v = ref_lfsr(v);
    end
    return s;
  endfunction

  initial begin
    logic [15:0] tbl [4];
    logic [34:0] one_vec;
    logic [15:0] exp_sig;
    int e, ndone;
    tbl[0] = 16'h1021; tbl[1] = 16'h3063; tbl[2] = 16'h70E7; tbl[3] = 16'hF1EF;
    one_vec = 35'h1;

    cmask = {$urandom(), $urandom()};
    cp = int'($urandom_range(34, 0));
    cq = int'($urandom_range(34, 0));

    // reset with start asserted
    RST_N = 1'b0; start_a = 1'b1; start_b = 1'b1; start_c = 1'b1; start_d = 1'b1;
    tick(); tick();
    check("rst_cone_in", 64'(ci_a), 64'(0));
    check("rst_busy", 64'({busy_a, busy_b, busy_c, busy_d}), 64'(0));
    check("rst_done", 64'({done_a, done_b, done_c, done_d}), 64'(0));
    check("rst_pass", 64'({pass_a, pass_z, pass_c, pass_d}), 64'(0));
    check("rst_sig", 64'(sig_a), 64'(0));
    check("rst_pat_cnt", 64'(pc_a), 64'(0));
    RST_N = 1'b1; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; start_d = 1'b0;
    tick(); tick(); tick();
    check("idle_after_rst_busy", 64'({busy_a, busy_b, busy_c, busy_d}), 64'(0));
    check("idle_after_rst_cone_in", 64'(ci_d), 64'(0));

    // constant-one cone, NPAT=4 SETTLE=1
    start_a = 1'b1; tick(); start_a = 1'b0;
    check("one_busy_seed", 64'(busy_a), 64'(1));
    for (int k = 1; k <= 11; k++) begin
      tick();
      check($sformatf("one_done_e%0d", k), 64'(done_a), 64'(k == 10));
      if (k >= 3 && k <= 9 && (k % 2) == 1) begin
        check($sformatf("one_sig_p%0d", (k - 1) / 2), 64'(sig_a), 64'(tbl[(k - 1) / 2 - 1]));
        check($sformatf("one_cnt_p%0d", (k - 1) / 2), 64'(pc_a), 64'((k - 1) / 2));
      end
      if (k == 10) begin
        check("one_pass_golden", 64'(pass_a), 64'(1));
        check("one_pass_zero_golden", 64'(pass_z), 64'(0));
        check("one_busy_done", 64'(busy_a), 64'(0));
      end
    end

    // start held high: second run only after DONE, SEED clears misr/pat_cnt
    start_a = 1'b1; tick();
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (k == 10) check("held_done1", 64'(done_a), 64'(1));
      if (k == 11) check("held_idle_busy", 64'(busy_a), 64'(0));
      if (k == 12) check("held_restart_busy", 64'(busy_a), 64'(1));
      if (k == 13) begin
        check("held_reseed_sig", 64'(sig_a), 64'(0));
        check("held_reseed_cnt", 64'(pc_a), 64'(0));
      end
    end
    start_a = 1'b0;
    ndone = 0;
    for (int k = 0; k < 30 && ndone == 0; k++) begin
      tick();
      if (done_a) ndone++;
    end
    check("held_done2_seen", 64'(ndone), 64'(1));
    check("held_pass2", 64'(pass_a), 64'(1));

    // LFSR sequence with SETTLE=3: vector constant across APPLY and CAPTURE
    start_b = 1'b1; tick(); start_b = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k <= 12)
        check($sformatf("seq_cone_in_e%0d", k), 64'(ci_b), 64'(one_vec << ((k - 1) / 4)));
      check($sformatf("seq_done_e%0d", k), 64'(done_b), 64'(k == 14));
    end

    // abort during the third APPLY
    start_c = 1'b1; tick(); start_c = 1'b0;
    for (int k = 1; k <= 5; k++) tick();
    check("ab_cnt_before", 64'(pc_c), 64'(2));
    abort_c = 1'b1; tick(); abort_c = 1'b0;
    check("ab_busy", 64'(busy_c), 64'(0));
    check("ab_pass", 64'(pass_c), 64'(0));
    check("ab_cnt_kept", 64'(pc_c), 64'(2));
    check("ab_sig_kept", 64'(sig_c), 64'(ref_sig(35'h1, 2, cmask, cp, cq)));
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      if (done_c) ndone++;
      tick();
    end
    check("ab_no_done", 64'(ndone), 64'(0));
    start_c = 1'b1; tick(); start_c = 1'b0;
    e = 0;
    while (!done_c && e < 40) begin
      tick(); e++;
    end
    exp_sig = ref_sig(35'h1, 8, cmask, cp, cq);
    check("ab_rerun_latency", 64'(e), 64'(18));
    check("ab_rerun_cnt", 64'(pc_c), 64'(8));
    check("ab_rerun_sig", 64'(sig_c), 64'(exp_sig));
    check("ab_rerun_pass", 64'(pass_c), 64'(exp_sig == 16'h0));

    // zero seed, random cone, 1024 patterns
    start_d = 1'b1; tick(); start_d = 1'b0;
    tick();
    check("rnd_first_vec", 64'(ci_d), 64'(1));
    e = 1;
    while (!done_d && e < 3200) begin
      tick(); e++;
    end
    exp_sig = ref_sig(35'h0, 1024, cmask, cp, cq);
    check("rnd_latency", 64'(e), 64'(2 + 3 * 1024));
    check("rnd_cnt", 64'(pc_d), 64'(1024));
    check("rnd_sig", 64'(sig_d), 64'(exp_sig));
    check("rnd_pass", 64'(pass_d), 64'(exp_sig == 16'h0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cone_lbist_ctrl.md
Name: cone_lbist_ctrl

Overview:
- Logic-BIST sequencer for the converted combinational partitions (e.g. single-output cones of s1423).
- Generates pseudo-random input vectors with an LFSR and drives them onto the cone inputs.
- Waits a programmable settle time, then compacts the cone output into a MISR.
- After NPAT patterns, compares the signature against a golden value and reports pass/fail.

Parameters:
- NIN, 35, cone input width; also the LFSR width.
- TAPS, 35'h5_0000_0000, LFSR feedback mask (bits 34 and 32, i.e. x^35+x^33+1).
- SEED, 35'h1, LFSR reset/seed value; a value of 0 is replaced by 1.
- NPAT, 1024, patterns per run (1..65535).
- SETTLE, 1, cycles cone_in is held before capture (1..15).
- GOLDEN, 16'h0000, expected final signature.

Ports:
- CK  in  1  clock, rising edge.
- RST_N  in  1  synchronous active-low reset.
- start  in  1  run request; sampled only in IDLE.
- abort  in  1  terminate the run and return to IDLE.
- cone_in  out  NIN  vector driven to the cone inputs.
- cone_out  in  1  cone output, e.g. n135.
- busy  out  1  high in any state other than IDLE and DONE.
- done  out  1  one-cycle pulse at end of run.
- pass  out  1  latched result; valid from done until the next start.
- signature  out  16  current MISR value.
- pat_cnt  out  16  patterns captured so far.

Behaviour:
- Reset (RST_N low at a CK edge):
  - State IDLE; lfsr=SEED (or 1); misr=0; pat_cnt=0; settle counter 0.
  - Outputs: cone_in=0, busy=0, done=0, pass=0, signature=0.
- States: IDLE, SEED, APPLY, CAPTURE, CHECK, DONE.
- IDLE, start=1 -> SEED.
- SEED (1 cycle):
  - lfsr=SEED (0 maps to 1), misr=0, pat_cnt=0, pass=0.
  - Next state: APPLY.
- APPLY:
  - cone_in=lfsr, held stable.
  - Stays SETTLE cycles (counter from 0 to SETTLE-1), then -> CAPTURE.
- CAPTURE (1 cycle):
  - cone_in still equals lfsr; cone_out is sampled at the CK edge ending this cycle.
  - MISR update: fb=misr[15]^cone_out; misr <= {misr[14:0],1'b0} ^ (fb ? 16'h1021 : 0).
  - LFSR advance: lfsr <= {lfsr[NIN-2:0], ^(lfsr & TAPS)}.
  - pat_cnt++.
  - If the new pat_cnt==NPAT -> CHECK, else -> APPLY.
- CHECK (1 cycle): pass <= (misr==GOLDEN); -> DONE.
- DONE (1 cycle): done=1; -> IDLE.
- cone_in outside APPLY/CAPTURE:
  - IDLE and DONE: holds the last applied vector, or 0 after reset.
  - SEED and CHECK: holds its previous value.
- Run latency: done is high in the cycle that starts 2+(SETTLE+1)*NPAT rising edges after the edge that sampled start in IDLE.
- start while not IDLE: ignored. start in DONE: ignored (only sampled in IDLE).
- abort:
  - Any non-IDLE state -> IDLE next edge; done not pulsed; pass=0.
  - misr and pat_cnt are kept for debug.
  - abort has priority over start and over every state transition.
- Simultaneous abort and RST_N low: reset wins.
- pat_cnt saturates at 16'hFFFF (unreachable with legal NPAT).
- signature mirrors misr combinationally; pat_cnt is a direct register output.
- No combinational path from cone_out to any output other than through misr.

Test Plan:
- Reset: hold RST_N=0 two cycles with start=1 -> cone_in=0, busy=0, done=0, pass=0, signature=0, pat_cnt=0; still IDLE after release while start=0.
- Constant-one cone: NPAT=4, SETTLE=1, cone_out tied 1, start pulsed at edge k:
  - signature steps 0x1021, 0x3063, 0x70E7, 0xF1EF;
  - done high in the cycle after edge k+10;
  - GOLDEN=0xF1EF -> pass=1; GOLDEN=0 -> pass=0.
- LFSR sequence: SEED=1, NPAT=3 -> cone_in in APPLY equals 35'h1, 35'h2, 35'h4; cone_in is constant across all SETTLE=3 cycles of each pattern.
- Abort mid-run: NPAT=8, assert abort during the 3rd APPLY -> IDLE next edge, no done pulse, pass=0, pat_cnt=2; a new start re-seeds and the run completes normally.
- Start handling: start held high throughout a run -> a second run begins only after the DONE cycle, with SEED reloading misr=0 and pat_cnt=0.
- Zero seed plus real cone: SEED=0 -> first vector 35'h1. Connect s1423 n135 with NPAT=1024 and compare signature with a software MISR model fed the same LFSR vectors.
